// File: rtl/addr_dec_split.sv
// Serial address decoder: deserialises an LSB-first device-ID prefix,
// accepts or rejects the request, then routes the offset bits to the
// selected slave. Tracks one outstanding split transaction and reselects
// its slave when the arbiter grants resumption.
module addr_dec_split #(
    parameter int  ADDR_WIDTH        = 16,
    parameter int  DEVICE_ADDR_WIDTH = 4,
    parameter int  NUM_SLAVE         = 3,
    localparam int CNT_W             = $clog2(ADDR_WIDTH) + 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         addr_valid,
    input  logic                         addr_data,
    input  logic [NUM_SLAVE-1:0]         sready,
    input  logic                         split,
    input  logic                         split_grant,
    output logic [DEVICE_ADDR_WIDTH-1:0] ssel,
    output logic                         ack,
    output logic                         nack,
    output logic [NUM_SLAVE-1:0]         mvalid,
    output logic                         split_busy,
    output logic [2:0]                   state_out,
    output logic [CNT_W-1:0]             counter_out
);

    localparam int OFF_BITS = ADDR_WIDTH - DEVICE_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEV_ADDR = 3'd1,
        DECODE   = 3'd2,
        FWD      = 3'd3
    } state_t;

    state_t                       state_reg, state_next;
    logic [CNT_W-1:0]             counter_reg, counter_next;
    logic [DEVICE_ADDR_WIDTH-1:0] dev_id_reg, dev_id_next;
    logic [DEVICE_ADDR_WIDTH-1:0] ssel_reg, ssel_next;
    logic [DEVICE_ADDR_WIDTH-1:0] split_id_reg, split_id_next;
    logic                         ack_reg, ack_next;
    logic                         nack_reg, nack_next;
    logic                         split_busy_reg, split_busy_next;
    logic                         grant_pending_reg, grant_pending_next;

    // One-hot decode of the captured device ID; an all-zero vector means unmapped.
    logic [NUM_SLAVE-1:0] dev_hit;
    logic                 dev_in_range;
    logic                 dev_ready;
    logic                 fwd_pass;

    generate
        for (genvar gi = 0; gi < NUM_SLAVE; gi++) begin : g_slave
            assign dev_hit[gi] = (dev_id_reg == DEVICE_ADDR_WIDTH'(gi));
            assign mvalid[gi]  = fwd_pass && (ssel_reg == DEVICE_ADDR_WIDTH'(gi));
        end
    endgenerate

    assign dev_in_range = |dev_hit;
    assign dev_ready    = |(dev_hit & sready);
    // A split cycle is never forwarded to the slave.
    assign fwd_pass     = (state_reg == FWD) && addr_valid && !split;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg         <= IDLE;
            counter_reg       <= '0;
            dev_id_reg        <= '0;
            ssel_reg          <= '0;
            split_id_reg      <= '0;
            ack_reg           <= 1'b0;
            nack_reg          <= 1'b0;
            split_busy_reg    <= 1'b0;
            grant_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            counter_reg       <= counter_next;
            dev_id_reg        <= dev_id_next;
            ssel_reg          <= ssel_next;
            split_id_reg      <= split_id_next;
            ack_reg           <= ack_next;
            nack_reg          <= nack_next;
            split_busy_reg    <= split_busy_next;
            grant_pending_reg <= grant_pending_next;
        end
    end

    // Next-state logic: prefix capture, decode decision, forwarding and split tracking.
    always_comb begin
        state_next         = state_reg;
        counter_next       = counter_reg;
        dev_id_next        = dev_id_reg;
        ssel_next          = ssel_reg;
        split_id_next      = split_id_reg;
        ack_next           = 1'b0;
        nack_next          = 1'b0;
        split_busy_next    = split_busy_reg;
        grant_pending_next = grant_pending_reg;

        // A grant is only meaningful while a split is outstanding; it is
        // remembered until the decoder is next idle.
        if (split_grant && split_busy_reg) begin
            grant_pending_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (grant_pending_reg) begin
                    ssel_next          = split_id_reg;
                    ack_next           = 1'b1;
                    split_busy_next    = 1'b0;
                    grant_pending_next = 1'b0;
                end else if (addr_valid) begin
                    dev_id_next    = '0;
                    dev_id_next[0] = addr_data;
                    if (DEVICE_ADDR_WIDTH == 1) begin
                        counter_next = '0;
                        state_next   = DECODE;
                    end else begin
                        counter_next = CNT_W'(1);
                        state_next   = DEV_ADDR;
                    end
                end
            end
            DEV_ADDR: begin
                if (addr_valid) begin
                    for (int i = 0; i < DEVICE_ADDR_WIDTH; i++) begin
                        if (counter_reg == CNT_W'(i)) begin
                            dev_id_next[i] = addr_data;
                        end
                    end
                    if (counter_reg == CNT_W'(DEVICE_ADDR_WIDTH - 1)) begin
                        counter_next = '0;
                        state_next   = DECODE;
                    end else begin
                        counter_next = counter_reg + 1'b1;
                    end
                end else begin
                    // Master gave up mid-prefix: drop it silently.
                    counter_next = '0;
                    state_next   = IDLE;
                end
            end
            DECODE: begin
                if (!dev_in_range
                    || (split_busy_reg && (dev_id_reg == split_id_reg))
                    || !dev_ready) begin
                    nack_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    ssel_next  = dev_id_reg;
                    ack_next   = 1'b1;
                    state_next = FWD;
                end
            end
            FWD: begin
                if (split) begin
                    // Only the first split is tracked; a second one still ends forwarding.
                    if (!split_busy_reg) begin
                        split_id_next   = ssel_reg;
                        split_busy_next = 1'b1;
                    end
                    counter_next = '0;
                    state_next   = IDLE;
                end else if (addr_valid) begin
                    if (counter_reg == CNT_W'(OFF_BITS - 1)) begin
                        counter_next = '0;
                        state_next   = IDLE;
                    end else begin
                        counter_next = counter_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ssel        = ssel_reg;
    assign ack         = ack_reg;
    assign nack        = nack_reg;
    assign split_busy  = split_busy_reg;
    assign state_out   = state_reg;
    assign counter_out = counter_reg;

endmodule
